interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 132 +++++++++++++
 tb/tb_interrupt_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Eight-source edge-triggered interrupt controller: pending/mask registers,
// lowest-index-first priority, vectored handler address and cause word.
module interrupt_controller #(
  parameter int M    = 16,
  parameter int N    = 32,
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic [1:0]      cfgSel,
  input  logic            cfgWE,
  input  logic [M-1:0]    cfgWData,
  output logic [M-1:0]    cfgRData,
  output logic            irq,
  input  logic            turnOffIRQ,
  output logic [N-1:0]    intAddr,
  output logic [M-1:0]    intData
);

  typedef enum logic [1:0] {IDLE, PRESENT, HOLDOFF} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            w_latch;
  logic [NSRC-1:0] r_src_d;
  logic            r_armed;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] r_mask;
  logic [M-1:0]    r_vlo;
  logic [M-1:0]    r_vhi;
  logic [2:0]      r_idx;
  logic [N-1:0]    r_addr;
  logic [M-1:0]    r_data;

  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_act;
  logic [NSRC-1:0] w_clr;
  logic [2:0]      w_idx;
  logic            w_ack;
  logic [2*M-1:0]  w_base;
  logic [N-1:0]    w_addr;
  logic [M-1:0]    w_cause;

  // r_armed masks the first cycle after reset so a line already high is not an edge
  assign w_rise = src & ~r_src_d & {NSRC{r_armed}};
  assign w_act  = r_pend & r_mask;
  assign w_ack  = (r_state == PRESENT) && turnOffIRQ;
  assign w_base = {r_vhi, r_vlo};
  assign w_addr = N'(w_base) + (N'(w_idx) << 3);

  always_comb begin
    w_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_idx = 3'(i);
    end
  end

  always_comb begin
    w_cause       = '0;
    w_cause[15:8] = r_pend;
    w_cause[2:0]  = w_idx;
  end

  always_comb begin
    w_clr = '0;
    if (cfgWE && cfgSel == 2'd1) w_clr = cfgWData[NSRC-1:0];
    if (w_ack) w_clr[r_idx] = 1'b1;
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_act) begin
          w_next  = PRESENT;
          w_latch = 1'b1;
        end
      end
      PRESENT: if (turnOffIRQ) w_next = HOLDOFF;
      HOLDOFF: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_src_d <= '0;
      r_armed <= 1'b0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_vlo   <= '0;
      r_vhi   <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_src_d <= src;
      r_armed <= 1'b1;
      // a new edge beats any clear landing in the same cycle
      r_pend  <= (r_pend & ~w_clr) | w_rise;
      if (cfgWE && cfgSel == 2'd0) r_mask <= cfgWData[NSRC-1:0];
      if (cfgWE && cfgSel == 2'd2) r_vlo  <= cfgWData;
      if (cfgWE && cfgSel == 2'd3) r_vhi  <= cfgWData;
      if (w_latch) begin
        r_idx  <= w_idx;
        r_addr <= w_addr;
        r_data <= w_cause;
      end
    end
  end

  always_comb begin
    case (cfgSel)
      2'd0:    cfgRData = M'(r_mask);
      2'd1:    cfgRData = M'(r_pend);
      2'd2:    cfgRData = r_vlo;
      default: cfgRData = r_vhi;
    endcase
  end

  assign irq     = (r_state == PRESENT);
  assign intAddr = r_addr;
  assign intData = r_data;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: presentation order, vector/cause
// words, masking, acknowledge/holdoff timing, W1C and reset behaviour.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  src;
  logic [1:0]  cfgSel;
  logic        cfgWE;
  logic [15:0] cfgWData;
  logic [15:0] cfgRData;
  logic        irq;
  logic        turnOffIRQ;
  logic [31:0] intAddr;
  logic [15:0] intData;

  int n_chk = 0;
  int n_err = 0;

  interrupt_controller #(.M(16), .N(32), .NSRC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .cfgSel     (cfgSel),
    .cfgWE      (cfgWE),
    .cfgWData   (cfgWData),
    .cfgRData   (cfgRData),
    .irq        (irq),
    .turnOffIRQ (turnOffIRQ),
    .intAddr    (intAddr),
    .intData    (intData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [1:0] sel, input logic [15:0] data);
    cfgSel   = sel;
    cfgWData = data;
    cfgWE    = 1'b1;
    tick();
    cfgWE    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    cfgSel = sel;
    #1;
    chk(tag, 32'(cfgRData), 32'(exp));
  endtask

  task automatic out3(input string tag, input logic e_irq, input logic [31:0] e_addr,
                      input logic [15:0] e_data);
    chk({tag, "_irq"}, 32'(irq), 32'(e_irq));
    chk({tag, "_addr"}, intAddr, e_addr);
    chk({tag, "_data"}, 32'(intData), 32'(e_data));
  endtask

  initial begin
    rst = 1'b0; src = '0; cfgSel = '0; cfgWE = 1'b0; cfgWData = '0; turnOffIRQ = 1'b0;
    tick(); tick();
    out3("rst", 1'b0, 32'h0, 16'h0);
    rd("rst_mask", 2'd0, 16'h0);
    rd("rst_pend", 2'd1, 16'h0);
    rd("rst_vlo", 2'd2, 16'h0);
    rd("rst_vhi", 2'd3, 16'h0);
    rst = 1'b1;
    tick();

    // single source, vector address and cause word
    cfg_wr(2'd2, 16'h2000);
    cfg_wr(2'd3, 16'h0001);
    cfg_wr(2'd0, 16'hFFFF);
    rd("mask_rd", 2'd0, 16'h00FF);
    rd("vlo_rd", 2'd2, 16'h2000);
    rd("vhi_rd", 2'd3, 16'h0001);
    src = 8'h08; tick(); src = 8'h00;
    chk("s3_early", 32'(irq), 32'd0);
    tick();
    out3("s3", 1'b1, 32'h0001_2018, 16'h0803);
    rd("s3_pend", 2'd1, 16'h0008);
    turnOffIRQ = 1'b1; tick(); turnOffIRQ = 1'b0;
    chk("s3_ack_irq", 32'(irq), 32'd0);
    rd("s3_ack_pend", 2'd1, 16'h0000);
    tick();

    // two pending, lowest first then the next after holdoff
    src = 8'h24; tick(); src = 8'h00; tick();
    out3("p2", 1'b1, 32'h0001_2010, 16'h2402);
    turnOffIRQ = 1'b1; tick(); turnOffIRQ = 1'b0;
    chk("p2_hold_irq", 32'(irq), 32'd0);
    rd("p2_hold_pend", 2'd1, 16'h0020);
    tick();
    chk("p2_idle_irq", 32'(irq), 32'd0);
    tick();
    out3("p5", 1'b1, 32'h0001_2028, 16'h2005);
    turnOffIRQ = 1'b1; tick(); turnOffIRQ = 1'b0; tick();

    // masked source latches but is not presented; ack ignored in IDLE
    cfg_wr(2'd0, 16'h0000);
    src = 8'h01; tick(); src = 8'h00; tick();
    chk("m0_irq", 32'(irq), 32'd0);
    rd("m0_pend", 2'd1, 16'h0001);
    turnOffIRQ = 1'b1; tick(); turnOffIRQ = 1'b0;
    rd("m0_ack_idle", 2'd1, 16'h0001);
    cfg_wr(2'd0, 16'h0001);
    tick();
    out3("m0_unmask", 1'b1, 32'h0001_2000, 16'h0100);
    turnOffIRQ = 1'b1; tick(); turnOffIRQ = 1'b0; tick();

    // re-edge coincident with acknowledge keeps the bit pending
    cfg_wr(2'd0, 16'h00FF);
    src = 8'h02; tick(); src = 8'h00; tick();
    out3("c1", 1'b1, 32'h0001_2008, 16'h0201);
    src = 8'h02; turnOffIRQ = 1'b1; tick(); src = 8'h00; turnOffIRQ = 1'b0;
    chk("c1_lo1", 32'(irq), 32'd0);
    rd("c1_pend", 2'd1, 16'h0002);
    tick();
    chk("c1_lo2", 32'(irq), 32'd0);
    tick();
    out3("c1_again", 1'b1, 32'h0001_2008, 16'h0201);

    // config changes while presenting do not disturb the outputs
    cfg_wr(2'd0, 16'h0000);
    cfg_wr(2'd2, 16'hFFFF);
    cfg_wr(2'd1, 16'h0002);
    rd("hold_w1c", 2'd1, 16'h0000);
    out3("hold", 1'b1, 32'h0001_2008, 16'h0201);
    turnOffIRQ = 1'b1; tick(); turnOffIRQ = 1'b0;
    chk("hold_ack", 32'(irq), 32'd0);
    tick();

    // vector add carries into the high word; reset mid-present
    cfg_wr(2'd0, 16'h00FF);
    src = 8'h80; tick(); tick();
    out3("s7", 1'b1, 32'h0002_0037, 16'h8007);
    rst = 1'b0; tick();
    out3("s7_rst", 1'b0, 32'h0, 16'h0);
    rd("s7_rst_mask", 2'd0, 16'h0);
    rd("s7_rst_pend", 2'd1, 16'h0);
    rst = 1'b1; tick();
    cfg_wr(2'd0, 16'h00FF);
    tick(); tick();
    chk("s7_held_irq", 32'(irq), 32'd0);
    rd("s7_held_pend", 2'd1, 16'h0000);
    src = 8'h00; tick();
    src = 8'h80; tick(); tick();
    out3("s7_new", 1'b1, 32'h0000_0038, 16'h8007);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
